// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch_unit
// Brief    : Decoupled RISC-V fetch front end with credit-based imem requests,
//            in-order instruction FIFO and redirect flush.
// Revision : 1.0
// ============================================================================
module riscv_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr_data,
    output logic [XLEN-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam int              c_OW      = c_AW + 1;
    localparam int              c_SW      = c_OW + 1;
    localparam int              c_QW      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [c_QW-1:0] c_QLAST   = c_QW'(MAX_OUT - 1);
    localparam logic [c_OW-1:0] c_MAX_OUT = c_OW'(MAX_OUT);
    localparam logic [c_SW-1:0] c_DEPTH   = c_SW'(DEPTH);

    logic [XLEN-1:0] r_fpc;
    logic [c_OW-1:0] r_inflight;
    logic [c_OW-1:0] r_discard;
    logic [c_OW-1:0] r_occ;
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_QW-1:0] r_pcq_wr;
    logic [c_QW-1:0] r_pcq_rd;
    logic [XLEN-1:0] r_fifo_pc   [DEPTH];
    logic [31:0]     r_fifo_data [DEPTH];
    logic [XLEN-1:0] r_pcq       [MAX_OUT];

    logic [c_SW-1:0] w_credit_sum;
    logic            w_rsp;
    logic            w_acc;
    logic            w_push;
    logic            w_pop;
    logic [c_QW-1:0] w_pcq_wr_nxt;
    logic [c_QW-1:0] w_pcq_rd_nxt;

    // Credits count both in-flight requests and buffered words, so every
    // response is guaranteed a FIFO slot.
    assign w_credit_sum   = {1'b0, r_inflight} + {1'b0, r_occ};
    assign imem_req_valid = rst_n && !redirect_valid && (r_inflight < c_MAX_OUT)
                            && (w_credit_sum < c_DEPTH);
    assign imem_req_addr  = r_fpc;

    assign w_rsp  = imem_rsp_valid && (r_inflight != '0);
    assign w_acc  = imem_req_valid && imem_req_ready;
    assign w_push = w_rsp && (r_discard == '0) && !redirect_valid;
    assign w_pop  = instr_valid && instr_ready && !redirect_valid;

    assign w_pcq_wr_nxt = (r_pcq_wr == c_QLAST) ? '0 : r_pcq_wr + 1'b1;
    assign w_pcq_rd_nxt = (r_pcq_rd == c_QLAST) ? '0 : r_pcq_rd + 1'b1;

    assign instr_valid = (r_occ != '0);
    assign instr_data  = instr_valid ? r_fifo_data[r_rptr] : '0;
    assign instr_pc    = instr_valid ? r_fifo_pc[r_rptr]   : '0;
    assign occupancy   = r_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc      <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_occ      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
        end else begin
            if (w_acc) r_pcq_wr <= w_pcq_wr_nxt;
            if (w_rsp) r_pcq_rd <= w_pcq_rd_nxt;
            r_inflight <= r_inflight + c_OW'(w_acc) - c_OW'(w_rsp);
            if (redirect_valid) begin
                // Everything still outstanding after this cycle belongs to the old path.
                r_fpc     <= redirect_pc & ~XLEN'(3);
                r_discard <= r_inflight - c_OW'(w_rsp);
                r_occ     <= '0;
                r_wptr    <= '0;
                r_rptr    <= '0;
            end else begin
                if (w_acc) r_fpc <= r_fpc + XLEN'(4);
                if (w_rsp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
                r_occ  <= r_occ + c_OW'(w_push) - c_OW'(w_pop);
                r_wptr <= r_wptr + c_AW'(w_push);
                r_rptr <= r_rptr + c_AW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) r_pcq[r_pcq_wr] <= r_fpc;
        if (w_push) begin
            r_fifo_pc[r_wptr]   <= r_pcq[r_pcq_rd];
            r_fifo_data[r_wptr] <= imem_rsp_data;
        end
    end

`ifndef SYNTHESIS
    a_rsp_with_credit: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (r_inflight != '0));
`endif

endmodule
`default_nettype wire
